axi_eth_txgen: RTL

- Bring-up traffic generator on the DMA side of the 10G TX path. Runs in the mm2s clock domain.
- Drives the AXI Ethernet TX control stream (txc, 32-bit) and the TX data stream (txd, 64-bit). These feed the txc/txd inputs of the MAC-side TX framer in place of AXI DMA MM2S.
- Produces a programmable number of frames with a deterministic, checkable payload, so the RX path can be verified end to end.

---
 rtl/axi_eth_txgen.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_eth_txgen.sv
// axi_eth_txgen: bring-up frame generator for the 10G TX path (txc 32-bit control, txd 64-bit data).
// Latency: txc_tvalid rises one cycle after an accepted start; every stream output is a register.
// Backpressure: a stalled stream (tvalid && !tready) holds its tdata/tkeep/tlast; optional stats via AXI_ETH_TXGEN_STATS_EN.
module axi_eth_txgen #(
   parameter logic [47:0] C_DST_MAC   = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] C_SRC_MAC   = 48'h000A_3500_0001,
   parameter logic [15:0] C_ETHERTYPE = 16'h88B5,
   parameter int          C_MAX_LEN   = 9018,
   parameter int          C_IFG       = 4
) (
   input  logic        mm2s_clk,
   input  logic        mm2s_resetn,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] frame_len,
   input  logic [15:0] frame_cnt,
   output logic [31:0] txc_tdata,
   output logic [3:0]  txc_tkeep,
   output logic        txc_tvalid,
   output logic        txc_tlast,
   input  logic        txc_tready,
   output logic [63:0] txd_tdata,
   output logic [7:0]  txd_tkeep,
   output logic        txd_tvalid,
   output logic        txd_tlast,
   input  logic        txd_tready,
   output logic        busy,
   output logic        done,
   output logic [31:0] frames_sent,
   output logic [31:0] byte_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CTRL = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_e;

   localparam logic [15:0]  MAX_LEN  = 16'(C_MAX_LEN);
   localparam logic [15:0]  MIN_LEN  = 16'd60;
   // GAP always lasts at least one cycle, even with no inter-frame gap configured.
   localparam logic [15:0]  GAP_LAST = (C_IFG == 0) ? 16'd0 : 16'(C_IFG - 1);
   // Frame header bytes 0..13 packed so that byte n sits at bits [8*(13-n) +: 8].
   localparam logic [111:0] HDR      = {C_DST_MAC, C_SRC_MAC, C_ETHERTYPE};

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] k_q, k_d;
   logic [2:0]  word_q, word_d;
   logic [12:0] beat_q, beat_d;
   logic [12:0] last_beat_q, last_beat_d;
   logic [15:0] gap_q, gap_d;
   logic        stop_q, stop_d;
   logic [31:0] txc_tdata_q, txc_tdata_d;
   logic [3:0]  txc_tkeep_q, txc_tkeep_d;
   logic        txc_tvalid_q, txc_tvalid_d;
   logic        txc_tlast_q, txc_tlast_d;
   logic [63:0] txd_tdata_q, txd_tdata_d;
   logic [7:0]  txd_tkeep_q, txd_tkeep_d;
   logic        txd_tvalid_q, txd_tvalid_d;
   logic        txd_tlast_q, txd_tlast_d;
   logic        done_q, done_d;
   logic [31:0] frames_q, frames_d;

   logic        txc_hs;
   logic        txd_hs;
   logic [15:0] len_clamp;
   logic [16:0] len_clamp_p7;
   logic [12:0] last_beat_new;
   logic [7:0]  last_keep;
   logic [12:0] nxt_beat;

   // Control word w of the current frame.
   function automatic logic [31:0] ctrl_word(input logic [2:0] w, input logic [15:0] len,
                                             input logic [31:0] k);
      logic [31:0] r;
      case (w)
         3'd0:    r = 32'hA000_0000;
         3'd4:    r = {16'h0000, len};
         3'd5:    r = k;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Eight frame bytes of data beat 'beat'; byte n lands in lane n%8.
   function automatic logic [63:0] data_beat(input logic [12:0] beat, input logic [7:0] k8);
      logic [63:0] d;
      logic [15:0] n;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         n = {beat, 3'(i)};
         if (n < 16'd14) begin
            d[8*i +: 8] = HDR[(13 - int'(n[3:0]))*8 +: 8];
         end else begin
            d[8*i +: 8] = n[7:0] + k8;
         end
      end
      return d;
   endfunction

   assign txc_hs        = txc_tvalid_q & txc_tready;
   assign txd_hs        = txd_tvalid_q & txd_tready;
   assign len_clamp     = (frame_len < MIN_LEN) ? MIN_LEN :
                          (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
   assign len_clamp_p7  = {1'b0, len_clamp} + 17'd7;
   assign last_beat_new = 13'((len_clamp_p7 >> 3) - 17'd1);
   assign last_keep     = (len_q[2:0] == 3'd0) ? 8'hFF : ((8'd1 << len_q[2:0]) - 8'd1);
   assign nxt_beat      = (state_q == S_CTRL) ? 13'd0 : (beat_q + 13'd1);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      word_d       = word_q;
      beat_d       = beat_q;
      last_beat_d  = last_beat_q;
      gap_d        = gap_q;
      stop_d       = stop_q;
      txc_tdata_d  = txc_tdata_q;
      txc_tkeep_d  = txc_tkeep_q;
      txc_tvalid_d = txc_tvalid_q;
      txc_tlast_d  = txc_tlast_q;
      txd_tdata_d  = txd_tdata_q;
      txd_tkeep_d  = txd_tkeep_q;
      txd_tvalid_d = txd_tvalid_q;
      txd_tlast_d  = txd_tlast_q;
      frames_d     = frames_q;
      done_d       = 1'b0;

      // A stop seen anywhere in a run is remembered until the frame ends.
      if (stop && (state_q != S_IDLE)) begin
         stop_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            stop_d = 1'b0;
            if (start && !stop) begin
               len_d        = len_clamp;
               cnt_d        = frame_cnt;
               k_d          = 32'd0;
               last_beat_d  = last_beat_new;
               word_d       = 3'd0;
               txc_tdata_d  = ctrl_word(3'd0, len_clamp, 32'd0);
               txc_tkeep_d  = 4'hF;
               txc_tvalid_d = 1'b1;
               txc_tlast_d  = 1'b0;
               state_d      = S_CTRL;
            end
         end
         S_CTRL: begin
            if (txc_hs) begin
               if (word_q == 3'd5) begin
                  // Control stream done; hand over to the data stream next cycle.
                  txc_tvalid_d = 1'b0;
                  txc_tlast_d  = 1'b0;
                  beat_d       = nxt_beat;
                  txd_tdata_d  = data_beat(nxt_beat, k_q[7:0]);
                  txd_tlast_d  = (nxt_beat == last_beat_q);
                  txd_tkeep_d  = (nxt_beat == last_beat_q) ? last_keep : 8'hFF;
                  txd_tvalid_d = 1'b1;
                  state_d      = S_DATA;
               end else begin
                  word_d      = word_q + 3'd1;
                  txc_tdata_d = ctrl_word(word_q + 3'd1, len_q, k_q);
                  txc_tlast_d = ((word_q + 3'd1) == 3'd5);
               end
            end
         end
         S_DATA: begin
            if (txd_hs) begin
               if (txd_tlast_q) begin
                  txd_tvalid_d = 1'b0;
                  txd_tlast_d  = 1'b0;
                  frames_d     = frames_q + 32'd1;
                  k_d          = k_q + 32'd1;
                  gap_d        = 16'd0;
                  state_d      = S_GAP;
               end else begin
                  beat_d      = nxt_beat;
                  txd_tdata_d = data_beat(nxt_beat, k_q[7:0]);
                  txd_tlast_d = (nxt_beat == last_beat_q);
                  txd_tkeep_d = (nxt_beat == last_beat_q) ? last_keep : 8'hFF;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               if (stop_q || stop) begin
                  state_d = S_IDLE;
               end else if ((cnt_q != 16'd0) && (k_q == {16'd0, cnt_q})) begin
                  state_d = S_IDLE;
               end else begin
                  word_d       = 3'd0;
                  txc_tdata_d  = ctrl_word(3'd0, len_q, k_q);
                  txc_tkeep_d  = 4'hF;
                  txc_tvalid_d = 1'b1;
                  txc_tlast_d  = 1'b0;
                  state_d      = S_CTRL;
               end
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         k_q          <= '0;
         word_q       <= '0;
         beat_q       <= '0;
         last_beat_q  <= '0;
         gap_q        <= '0;
         stop_q       <= 1'b0;
         txc_tdata_q  <= '0;
         txc_tkeep_q  <= '0;
         txc_tvalid_q <= 1'b0;
         txc_tlast_q  <= 1'b0;
         txd_tdata_q  <= '0;
         txd_tkeep_q  <= '0;
         txd_tvalid_q <= 1'b0;
         txd_tlast_q  <= 1'b0;
         done_q       <= 1'b0;
         frames_q     <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         word_q       <= word_d;
         beat_q       <= beat_d;
         last_beat_q  <= last_beat_d;
         gap_q        <= gap_d;
         stop_q       <= stop_d;
         txc_tdata_q  <= txc_tdata_d;
         txc_tkeep_q  <= txc_tkeep_d;
         txc_tvalid_q <= txc_tvalid_d;
         txc_tlast_q  <= txc_tlast_d;
         txd_tdata_q  <= txd_tdata_d;
         txd_tkeep_q  <= txd_tkeep_d;
         txd_tvalid_q <= txd_tvalid_d;
         txd_tlast_q  <= txd_tlast_d;
         done_q       <= done_d;
         frames_q     <= frames_d;
      end
   end

   assign txc_tdata   = txc_tdata_q;
   assign txc_tkeep   = txc_tkeep_q;
   assign txc_tvalid  = txc_tvalid_q;
   assign txc_tlast   = txc_tlast_q;
   assign txd_tdata   = txd_tdata_q;
   assign txd_tkeep   = txd_tkeep_q;
   assign txd_tvalid  = txd_tvalid_q;
   assign txd_tlast   = txd_tlast_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign frames_sent = frames_q;

`ifdef AXI_ETH_TXGEN_STATS_EN
   logic [31:0] byte_cnt_q, byte_cnt_d;
   logic [3:0]  keep_ones;

   // Add the number of enabled lanes of every accepted data beat.
   always_comb begin
      keep_ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         keep_ones = keep_ones + {3'd0, txd_tkeep_q[i]};
      end
      byte_cnt_d = byte_cnt_q;
      if (txd_hs) begin
         byte_cnt_d = byte_cnt_q + {28'd0, keep_ones};
      end
   end

   // Byte counter register, wraps at 2^32.
   always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         byte_cnt_q <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign byte_cnt = byte_cnt_q;
`else
   assign byte_cnt = 32'd0;
`endif

endmodule
